// File: rtl/conversor_bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter: FSM encoding,
// digit geometry, the add-3 threshold and the active-low 7-segment table.
package conversor_bcd_pkg;

    localparam int unsigned N_DIGITS    = 3;
    localparam int unsigned DIGIT_W     = 4;
    localparam int unsigned BCD_W       = N_DIGITS * DIGIT_W;
    localparam int unsigned ADD3_THRESH = 5;
    localparam int unsigned SEG_W       = 7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DESLOCA = 2'd1,
        FIM     = 2'd2
    } estado_t;

    // Double-dabble correction applied to one scratch digit before each shift
    function automatic logic [DIGIT_W-1:0] add3(input logic [DIGIT_W-1:0] d);
        return (d >= DIGIT_W'(ADD3_THRESH)) ? d + DIGIT_W'(3) : d;
    endfunction

    // Active-low segments, bit order gfedcba; non-decimal codes blank the digit
    function automatic logic [SEG_W-1:0] seg7(input logic [DIGIT_W-1:0] d);
        logic [SEG_W-1:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/decodificador_7seg.sv
// One BCD digit to active-low gfedcba segments, purely combinational.
module decodificador_7seg
    import conversor_bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [SEG_W-1:0]   seg_o
);

    assign seg_o = seg7(digit_i);

endmodule

// File: rtl/conversor_bcd.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Define CONVERSOR_BCD_SEG7_EN to add the Seg_C/Seg_D/Seg_U 7-segment outputs.
module conversor_bcd
    import conversor_bcd_pkg::*;
#(
    parameter int unsigned W = 8
)
(
    input  logic               Clk,
    input  logic               Rst,
    input  logic               St,
    input  logic [W-1:0]       Produto,
    output logic               Idle,
    output logic               Done,
    output logic [DIGIT_W-1:0] Centena,
    output logic [DIGIT_W-1:0] Dezena,
    output logic [DIGIT_W-1:0] Unidade
`ifdef CONVERSOR_BCD_SEG7_EN
    ,
    output logic [SEG_W-1:0]   Seg_C,
    output logic [SEG_W-1:0]   Seg_D,
    output logic [SEG_W-1:0]   Seg_U
`endif
);

    localparam int unsigned CNT_W   = $clog2(W + 1);
    localparam int unsigned CHAIN_W = BCD_W + W;

    estado_t            state_q, state_d;
    logic [W-1:0]       shift_q, shift_d;
    logic [BCD_W-1:0]   bcd_q,   bcd_d;
    logic [BCD_W-1:0]   dig_q,   dig_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    logic [BCD_W-1:0]   bcd_adj;
    logic [CHAIN_W-1:0] chain;
    logic               last_bit;

    // Correct every scratch digit, then shift the whole chain one bit left
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < int'(N_DIGITS); i++) begin
            bcd_adj[i*DIGIT_W +: DIGIT_W] = add3(bcd_q[i*DIGIT_W +: DIGIT_W]);
        end
        chain = {bcd_adj, shift_q} << 1;
    end

    assign last_bit = (cnt_q == CNT_W'(1));

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (St) state_d = DESLOCA;
            DESLOCA: if (last_bit) state_d = FIM;
            FIM:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        Idle = (state_q == IDLE);
        Done = (state_q == FIM);
    end

    // Datapath; the visible digits only change on the final shift
    always_comb begin
        shift_d = shift_q;
        bcd_d   = bcd_q;
        dig_d   = dig_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (St) begin
                    shift_d = Produto;
                    bcd_d   = '0;
                    cnt_d   = CNT_W'(W);
                end
            end
            DESLOCA: begin
                bcd_d   = chain[CHAIN_W-1 -: BCD_W];
                shift_d = chain[W-1:0];
                cnt_d   = cnt_q - CNT_W'(1);
                if (last_bit) dig_d = chain[CHAIN_W-1 -: BCD_W];
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            shift_q <= '0;
            bcd_q   <= '0;
            dig_q   <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            dig_q   <= dig_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Centena = dig_q[2*DIGIT_W +: DIGIT_W];
    assign Dezena  = dig_q[1*DIGIT_W +: DIGIT_W];
    assign Unidade = dig_q[0*DIGIT_W +: DIGIT_W];

`ifdef CONVERSOR_BCD_SEG7_EN
    decodificador_7seg u_seg_c (.digit_i(Centena), .seg_o(Seg_C));
    decodificador_7seg u_seg_d (.digit_i(Dezena),  .seg_o(Seg_D));
    decodificador_7seg u_seg_u (.digit_i(Unidade), .seg_o(Seg_U));
`endif

endmodule

// File: tb/tb_conversor_bcd.sv
// Directed bench for conversor_bcd (W=8); seg outputs checked when
// CONVERSOR_BCD_SEG7_EN is defined.
module tb_conversor_bcd;

    localparam int unsigned W = 8;

    logic         Clk = 1'b0;
    logic         Rst;
    logic         St;
    logic [W-1:0] Produto;
    logic         Idle;
    logic         Done;
    logic [3:0]   Centena;
    logic [3:0]   Dezena;
    logic [3:0]   Unidade;
`ifdef CONVERSOR_BCD_SEG7_EN
    logic [6:0]   Seg_C;
    logic [6:0]   Seg_D;
    logic [6:0]   Seg_U;
`endif

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    conversor_bcd #(.W(W)) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .St      (St),
        .Produto (Produto),
        .Idle    (Idle),
        .Done    (Done),
        .Centena (Centena),
        .Dezena  (Dezena),
        .Unidade (Unidade)
`ifdef CONVERSOR_BCD_SEG7_EN
        ,
        .Seg_C   (Seg_C),
        .Seg_D   (Seg_D),
        .Seg_U   (Seg_U)
`endif
    );

    // Returns at the falling edge after the accepting rising edge
    task automatic pulse_st(input logic [W-1:0] val);
        @(negedge Clk);
        Produto = val;
        St      = 1'b1;
        @(negedge Clk);
        St      = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b1; St = 1'b0; Produto = '0;
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        checks++;
        if (Idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %b want 1", Idle); end
        checks++;
        if (Done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", Done); end
        checks++;
        if ({Centena, Dezena, Unidade} !== 12'h000)
            begin errors++; $display("FAIL reset_digits got %h want 000", {Centena, Dezena, Unidade}); end
    endtask

    task automatic test_fifty();
        pulse_st(8'h32);
        checks++;
        if (Idle !== 1'b0) begin errors++; $display("FAIL fifty_busy got Idle=%b want 0", Idle); end
        for (int i = 1; i < int'(W); i++) begin
            @(negedge Clk);
            checks++;
            if (Done !== 1'b0) begin errors++; $display("FAIL fifty_early_done cycle %0d got %b want 0", i, Done); end
        end
        @(negedge Clk);
        checks++;
        if (Done !== 1'b1 || Idle !== 1'b0)
            begin errors++; $display("FAIL fifty_done got Done=%b Idle=%b want 1/0", Done, Idle); end
        checks++;
        if ({Centena, Dezena, Unidade} !== 12'h050)
            begin errors++; $display("FAIL fifty_digits got %h want 050", {Centena, Dezena, Unidade}); end
        @(negedge Clk);
        checks++;
        if (Done !== 1'b0 || Idle !== 1'b1)
            begin errors++; $display("FAIL fifty_after got Done=%b Idle=%b want 0/1", Done, Idle); end
    endtask

    task automatic test_zero();
        pulse_st(8'h00);
        repeat (W - 1) @(negedge Clk);
        checks++;
        if ({Centena, Dezena, Unidade} !== 12'h050)
            begin errors++; $display("FAIL zero_hold got %h want 050", {Centena, Dezena, Unidade}); end
        @(negedge Clk);
        checks++;
        if (Done !== 1'b1) begin errors++; $display("FAIL zero_done got %b want 1", Done); end
        checks++;
        if ({Centena, Dezena, Unidade} !== 12'h000)
            begin errors++; $display("FAIL zero_digits got %h want 000", {Centena, Dezena, Unidade}); end
        @(negedge Clk);
    endtask

    task automatic test_225();
        pulse_st(8'hE1);
        repeat (W) @(negedge Clk);
        checks++;
        if (Done !== 1'b1) begin errors++; $display("FAIL e1_done got %b want 1", Done); end
        checks++;
        if ({Centena, Dezena, Unidade} !== 12'h225)
            begin errors++; $display("FAIL e1_digits got %h want 225", {Centena, Dezena, Unidade}); end
`ifdef CONVERSOR_BCD_SEG7_EN
        checks++;
        if (Seg_C !== 7'b0100100 || Seg_D !== 7'b0100100 || Seg_U !== 7'b0010010)
            begin errors++; $display("FAIL e1_segs got %b %b %b want 0100100 0100100 0010010", Seg_C, Seg_D, Seg_U); end
`endif
        @(negedge Clk);
    endtask

    task automatic test_255_ignore();
        int          n_done;
        logic [11:0] seen;
        n_done = 0;
        seen   = '0;
        pulse_st(8'hFF);
        @(negedge Clk);
        St = 1'b1; Produto = 8'h00;
        repeat (3) @(negedge Clk);
        St = 1'b0;
        checks++;
        if ({Centena, Dezena, Unidade} !== 12'h225)
            begin errors++; $display("FAIL ff_hold got %h want 225", {Centena, Dezena, Unidade}); end
        for (int i = 0; i < 12; i++) begin
            @(negedge Clk);
            if (Done === 1'b1) begin
                n_done++;
                seen = {Centena, Dezena, Unidade};
            end
        end
        checks++;
        if (n_done != 1) begin errors++; $display("FAIL ff_done_count got %0d want 1", n_done); end
        checks++;
        if (seen !== 12'h255) begin errors++; $display("FAIL ff_digits got %h want 255", seen); end
        checks++;
        if (Idle !== 1'b1) begin errors++; $display("FAIL ff_idle got %b want 1", Idle); end
    endtask

    task automatic test_reset_abort();
        int n_done;
        n_done = 0;
        pulse_st(8'hFF);
        repeat (3) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        checks++;
        if (Idle !== 1'b1 || Done !== 1'b0)
            begin errors++; $display("FAIL abort_state got Idle=%b Done=%b want 1/0", Idle, Done); end
        checks++;
        if ({Centena, Dezena, Unidade} !== 12'h000)
            begin errors++; $display("FAIL abort_digits got %h want 000", {Centena, Dezena, Unidade}); end
        for (int i = 0; i < 12; i++) begin
            @(negedge Clk);
            if (Done === 1'b1) n_done++;
        end
        checks++;
        if (n_done != 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", n_done); end
        pulse_st(8'h32);
        repeat (W) @(negedge Clk);
        checks++;
        if (Done !== 1'b1 || {Centena, Dezena, Unidade} !== 12'h050)
            begin errors++; $display("FAIL abort_restart got Done=%b digits=%h want 1/050", Done, {Centena, Dezena, Unidade}); end
        @(negedge Clk);
    endtask

    task automatic test_st_held();
        int last;
        int n_done;
        last   = -1;
        n_done = 0;
        @(negedge Clk);
        Produto = 8'h19;
        St      = 1'b1;
        for (int i = 0; i < 4 * int'(W + 2); i++) begin
            @(negedge Clk);
            if (Done === 1'b1) begin
                n_done++;
                checks++;
                if ({Centena, Dezena, Unidade} !== 12'h025)
                    begin errors++; $display("FAIL held_digits pulse %0d got %h want 025", n_done, {Centena, Dezena, Unidade}); end
                if (last >= 0) begin
                    checks++;
                    if (i - last != int'(W + 2))
                        begin errors++; $display("FAIL held_period got %0d want %0d", i - last, W + 2); end
                end
                last = i;
            end
        end
        St = 1'b0;
        checks++;
        if (n_done < 3) begin errors++; $display("FAIL held_count got %0d want >=3", n_done); end
        for (int i = 0; i < 2 * int'(W + 2) && Idle !== 1'b1; i++) @(negedge Clk);
        @(negedge Clk);
        checks++;
        if (Idle !== 1'b1) begin errors++; $display("FAIL held_drain got Idle=%b want 1", Idle); end
    endtask

    initial begin
        test_reset();
        test_fifty();
        test_zero();
        test_225();
        test_255_ignore();
        test_reset_abort();
        test_st_held();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conversor_bcd.md
CONVERSOR_BCD -- requirements
Module: conversor_bcd

Interface
REQ-001 Parameter: W, 8, width of the binary input; legal range 4..9, so the result always fits in three BCD digits.
REQ-002 The block SHALL have exactly these ports:
- Clk  input  1  clock, all state updates on rising edge.
- Rst  input  1  synchronous reset, active-high.
- St  input  1  start request, sampled only in IDLE; connects to the multiplier's Done.
- Produto  input  W  unsigned binary value, captured on accepted St.
- Idle  output  1  high while in IDLE.
- Done  output  1  one-cycle pulse on completion.
- Centena  output  4  hundreds BCD digit.
- Dezena  output  4  tens BCD digit.
- Unidade  output  4  units BCD digit.

Function
REQ-003 Sequential double-dabble (shift-and-add-3) conversion SHALL be used, one bit per clock; no combinational divide.
REQ-004 The FSM SHALL have exactly three states: IDLE, DESLOCA, FIM.
REQ-005 IDLE: Idle=1; on an edge with St=1, capture Produto into the shift register, clear the BCD scratch digits, load the bit counter with W, go to DESLOCA.
REQ-006 DESLOCA, each edge: every scratch digit >=5 gets +3, then the {scratch digits, shift register} chain shifts left one bit (Produto MSB first) and the counter decrements.
REQ-007 On the edge where the counter reaches 0, go to FIM; on that same edge Centena/Dezena/Unidade SHALL load the final digits.
REQ-008 FIM: Done=1 for exactly one cycle, Idle=0; next edge unconditionally to IDLE.
REQ-009 Latency: St accepted at edge k -> outputs valid and Done=1 in the cycle after edge k+W -> Idle=1 after edge k+W+1.
REQ-010 St in DESLOCA or FIM SHALL be ignored and not queued.
REQ-011 Produto changes after capture SHALL NOT affect the conversion in progress.
REQ-012 St held high continuously SHALL start a new conversion on every IDLE cycle, period W+2.
REQ-013 Digit outputs SHALL hold the last result until the next completion; they never show partial values.
REQ-014 Each digit SHALL be 0..9 at all times; for W=9, inputs >=500 give Centena 5.

Reset
REQ-015 Rst=1 at an edge SHALL force IDLE, Idle=1, Done=0, all digits 0, counter 0, and clear the shift register and scratch, from any state.
REQ-016 Reset mid-conversion SHALL abort it with no Done pulse.
REQ-017 Rst SHALL take priority over St on the same edge.

Configuration
REQ-018 Macro CONVERSOR_BCD_SEG7_EN defined: the block SHALL add outputs Seg_C, Seg_D, Seg_U [6:0], active-low, bit order gfedcba, decoded combinationally from the registered digits.
REQ-019 Macro undefined: those ports and the decoder SHALL be absent; all other behaviour identical.

Structure
REQ-020 A shared package/header SHALL hold the state encodings, the digit count (3), the add-3 threshold (5) and the 7-segment table.
REQ-021 A single sub-module, decodificador_7seg (4-bit digit in, 7-bit active-low segments out), SHALL be instantiated three times, only under the macro.

Verification
REQ-022 The bench SHALL cover:
- Produto=0x00, St pulse -> after W+1 edges Done=1, digits 0/0/0.
- Produto=0x32 (5*10) -> digits 0/5/0, Done exactly one cycle, Idle=1 one cycle later.
- Produto=0xE1 (15*15) -> digits 2/2/5; with the macro, Seg_C=Seg_D=0100100 and Seg_U=0010010.
- Produto=0xFF, then St re-asserted and Produto=0x00 mid-conversion -> result 2/5/5, second St ignored, a single Done.
- Reset asserted at the 4th DESLOCA cycle -> no Done, digits 0, Idle=1 next cycle; a fresh St with 0x32 gives 0/5/0.
- St tied high with Produto=0x19 -> Done every W+2 cycles, digits 0/2/5 each time.
